// File: rtl/select_my_action.sv
// rtl/select_my_action.sv - forwarding-role selection with optional flag write-back
// Write-back sequence is built only when SMA_MEM_WRITEBACK_EN is defined.
module select_my_action #(
   parameter int WORD_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 11,
   parameter int SINK_ID_BASE = 64,
   parameter logic [ADDR_WIDTH-1:0] FLAG_BASE = 11'h000
) (
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  wr_en,
   input  logic [WORD_WIDTH-1:0] nexthop,
   input  logic [WORD_WIDTH-1:0] nextsinks,
   output logic [WORD_WIDTH-1:0] action,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  forAggregation,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, DECIDE, WR_AGG, WR_CODE, WR_HOP, DONE} state_t;

   state_t                state, next_state;
   logic                  is_self, is_sink, done_next;
   logic [1:0]            dec_code;
   logic [WORD_WIDTH-1:0] dec_action;

   always_comb begin
      is_self    = (nexthop == nextsinks);
      is_sink    = (nexthop >= WORD_WIDTH'(SINK_ID_BASE));
      dec_action = nexthop;
      dec_code   = 2'd0;
      if (is_self) begin
         dec_code = 2'd2;
      end else if (is_sink) begin
         dec_action = nextsinks;
         dec_code   = 2'd1;
      end
   end

   always_comb begin
      next_state = state;
      if (en) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) next_state = DECIDE;
`ifdef SMA_MEM_WRITEBACK_EN
            DECIDE:  next_state = WR_AGG;
            WR_AGG:  next_state = WR_CODE;
            WR_CODE: next_state = WR_HOP;
            WR_HOP:  next_state = DONE;
`else
            DECIDE:  next_state = DONE;
`endif
            DONE:    next_state = DONE;
            default: next_state = IDLE;
         endcase
      end
   end

`ifdef SMA_MEM_WRITEBACK_EN
   // done rises on the edge that leaves the last write state
   assign done_next = !en && ((state == WR_HOP) || (state == DONE));
`else
   assign done_next = !en && (state == DONE);
`endif

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state          <= IDLE;
         action         <= '0;
         forAggregation <= 1'b0;
         done           <= 1'b0;
      end else begin
         state <= next_state;
         done  <= done_next;
         if (state == DECIDE && !en) begin
            action         <= dec_action;
            forAggregation <= is_self;
         end
      end
   end

`ifdef SMA_MEM_WRITEBACK_EN
   localparam logic [ADDR_WIDTH-1:0] AGG_ADDR  = FLAG_BASE + ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] CODE_ADDR = FLAG_BASE + ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] HOP_ADDR  = FLAG_BASE + ADDR_WIDTH'(6);

   logic [1:0]            code_r;
   logic [ADDR_WIDTH-1:0] address_r;
   logic [WORD_WIDTH-1:0] data_r;
   logic                  wr_en_r;

   // Each write word is staged on the edge entering its WR_* state.
   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         code_r    <= 2'd0;
         address_r <= '0;
         data_r    <= '0;
         wr_en_r   <= 1'b0;
      end else begin
         wr_en_r <= 1'b0;
         if (!en) begin
            case (state)
               DECIDE: begin
                  code_r    <= dec_code;
                  wr_en_r   <= 1'b1;
                  address_r <= AGG_ADDR;
                  data_r    <= {{(WORD_WIDTH-1){1'b0}}, is_self};
               end
               WR_AGG: begin
                  wr_en_r   <= 1'b1;
                  address_r <= CODE_ADDR;
                  data_r    <= {{(WORD_WIDTH-2){1'b0}}, code_r};
               end
               WR_CODE: begin
                  wr_en_r   <= 1'b1;
                  address_r <= HOP_ADDR;
                  data_r    <= action;
               end
               default: ;
            endcase
         end
      end
   end

   assign address  = address_r;
   assign data_out = data_r;
   assign wr_en    = wr_en_r;
`else
   assign address  = FLAG_BASE & {ADDR_WIDTH{1'b0}};
   assign data_out = '0;
   assign wr_en    = 1'b0;
`endif

endmodule

// File: tb/tb_select_my_action.sv
// tb/tb_select_my_action.sv - directed bench for select_my_action
// Expectations follow SMA_MEM_WRITEBACK_EN when it is defined.
module tb_select_my_action;

`ifdef SMA_MEM_WRITEBACK_EN
   localparam int LAT    = 5;
   localparam int NWR    = 3;
   localparam int NABORT = 2;
`else
   localparam int LAT    = 3;
   localparam int NWR    = 0;
   localparam int NABORT = 0;
`endif

   logic        clock = 1'b0;
   logic        nrst, en, start;
   logic [10:0] address;
   logic        wr_en;
   logic [15:0] nexthop, nextsinks, action, data_out;
   logic        forAggregation, done;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [10:0] wa[$];
   logic [15:0] wd[$];

   select_my_action dut (
      .clock(clock), .nrst(nrst), .en(en), .start(start),
      .address(address), .wr_en(wr_en),
      .nexthop(nexthop), .nextsinks(nextsinks),
      .action(action), .data_out(data_out),
      .forAggregation(forAggregation), .done(done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (nrst && wr_en === 1'b1) begin
         wa.push_back(address);
         wd.push_back(data_out);
      end
   end

   task automatic pulse_en();
      en = 1'b1;
      @(posedge clock); #1;
      en = 1'b0;
   endtask

   task automatic do_run(input logic [15:0] nh, input logic [15:0] ns, input logic [15:0] exp_act,
                         input logic exp_fa, input logic [1:0] exp_code, input string name);
      int n;
      logic [10:0] ea[3];
      logic [15:0] ed[3];
      ea[0] = 11'h002; ea[1] = 11'h004; ea[2] = 11'h006;
      ed[0] = {15'b0, exp_fa}; ed[1] = {14'b0, exp_code}; ed[2] = exp_act;
      wa.delete(); wd.delete();
      nexthop = nh; nextsinks = ns; start = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clock); #1;
         n++;
         if (n == 2) begin
            nexthop = ~nh; nextsinks = ~ns;
         end
         if (done === 1'b1) break;
      end
      total_cnt++;
      if (n !== LAT) $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, LAT);
      else pass_cnt++;
      total_cnt++;
      if (action !== exp_act) $display("FAIL %s action: got %0d, expected %0d", name, action, exp_act);
      else pass_cnt++;
      total_cnt++;
      if (forAggregation !== exp_fa) $display("FAIL %s forAggregation: got %b, expected %b", name, forAggregation, exp_fa);
      else pass_cnt++;
      total_cnt++;
      if (wr_en !== 1'b0) $display("FAIL %s wr_en at done: got %b, expected 0", name, wr_en);
      else pass_cnt++;
      total_cnt++;
      if (wa.size() !== NWR) $display("FAIL %s write count: got %0d, expected %0d", name, wa.size(), NWR);
      else pass_cnt++;
      for (int i = 0; i < NWR; i++) begin
         if (i < wa.size()) begin
            total_cnt++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i])
               $display("FAIL %s write %0d: got addr 0x%03h data %0d, expected addr 0x%03h data %0d",
                        name, i, wa[i], wd[i], ea[i], ed[i]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({action, data_out, address, wr_en, forAggregation, done} !== '0)
         $display("FAIL reset_init: got action %0d data %0d addr %0d wr_en %b fa %b done %b, expected all 0",
                  action, data_out, address, wr_en, forAggregation, done);
      else pass_cnt++;
      @(posedge clock); #1;
      nrst = 1'b1;
      nexthop = 16'd51; nextsinks = 16'd65; start = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      total_cnt++;
      if (action !== 16'd51) $display("FAIL reset_pre action: got %0d, expected 51", action);
      else pass_cnt++;
      nrst = 1'b0;
      #1;
      total_cnt++;
      if (action !== 16'd0) $display("FAIL reset_mid action: got %0d, expected 0", action);
      else pass_cnt++;
      total_cnt++;
      if (wr_en !== 1'b0) $display("FAIL reset_mid wr_en: got %b, expected 0", wr_en);
      else pass_cnt++;
      total_cnt++;
      if (address !== 11'd0 || data_out !== 16'd0)
         $display("FAIL reset_mid addr/data: got addr %0d data %0d, expected 0 0", address, data_out);
      else pass_cnt++;
      total_cnt++;
      if (forAggregation !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_mid fa/done: got %b %b, expected 0 0", forAggregation, done);
      else pass_cnt++;
      start = 1'b0;
      @(posedge clock); #1;
      nrst = 1'b1;
      wa.delete(); wd.delete();
      repeat (3) @(posedge clock);
      #1;
      total_cnt++;
      if (wr_en !== 1'b0 || wa.size() !== 0)
         $display("FAIL reset_release: got wr_en %b writes %0d, expected 0 0", wr_en, wa.size());
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_release done: got %b, expected 0", done);
      else pass_cnt++;
   endtask

   task automatic test_best_hop();
      do_run(16'd51, 16'd65, 16'd51, 1'b0, 2'd0, "best_hop");
      start = 1'b0;
   endtask

   task automatic test_next_sink();
      pulse_en();
      do_run(16'd65, 16'd45, 16'd45, 1'b0, 2'd1, "next_sink");
      start = 1'b0;
   endtask

   task automatic test_self();
      pulse_en();
      do_run(16'd65, 16'd65, 16'd65, 1'b1, 2'd2, "self");
      start = 1'b0;
   endtask

   task automatic test_hold_start();
      int n;
      pulse_en();
      do_run(16'd40, 16'd30, 16'd40, 1'b0, 2'd0, "hold_run");
      repeat (20) @(posedge clock);
      #1;
      total_cnt++;
      if (done !== 1'b1) $display("FAIL hold done: got %b, expected 1", done);
      else pass_cnt++;
      total_cnt++;
      if (wa.size() !== NWR) $display("FAIL hold writes: got %0d, expected %0d", wa.size(), NWR);
      else pass_cnt++;
      nexthop = 16'd70; nextsinks = 16'd90;
      pulse_en();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL hold en_clear done: got %b, expected 0", done);
      else pass_cnt++;
      n = 0;
      while (n < 20) begin
         @(posedge clock); #1;
         n++;
         if (done === 1'b1) break;
      end
      total_cnt++;
      if (n !== LAT) $display("FAIL hold rerun latency: got %0d, expected %0d", n, LAT);
      else pass_cnt++;
      total_cnt++;
      if (action !== 16'd90) $display("FAIL hold rerun action: got %0d, expected 90", action);
      else pass_cnt++;
      total_cnt++;
      if (wa.size() !== 2 * NWR) $display("FAIL hold rerun writes: got %0d, expected %0d", wa.size(), 2 * NWR);
      else pass_cnt++;
      start = 1'b0;
   endtask

   task automatic test_abort();
      logic hop_written;
      pulse_en();
      wa.delete(); wd.delete();
      nexthop = 16'd51; nextsinks = 16'd65; start = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      en = 1'b1; start = 1'b0;
      @(posedge clock); #1;
      total_cnt++;
      if (wr_en !== 1'b0 || done !== 1'b0)
         $display("FAIL abort next: got wr_en %b done %b, expected 0 0", wr_en, done);
      else pass_cnt++;
      en = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      hop_written = 1'b0;
      foreach (wa[i]) if (wa[i] === 11'h006) hop_written = 1'b1;
      total_cnt++;
      if (wa.size() !== NABORT) $display("FAIL abort writes: got %0d, expected %0d", wa.size(), NABORT);
      else pass_cnt++;
      total_cnt++;
      if (hop_written !== 1'b0) $display("FAIL abort hop_write: got 1, expected 0");
      else pass_cnt++;
      total_cnt++;
      if (done !== 1'b0 || wr_en !== 1'b0)
         $display("FAIL abort idle: got done %b wr_en %b, expected 0 0", done, wr_en);
      else pass_cnt++;
      total_cnt++;
      if (action !== 16'd51) $display("FAIL abort action hold: got %0d, expected 51", action);
      else pass_cnt++;
   endtask

   initial begin
      nrst = 1'b0; en = 1'b0; start = 1'b0;
      nexthop = '0; nextsinks = '0;
      test_reset();
      test_best_hop();
      test_next_sink();
      test_self();
      test_hold_start();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/select_my_action.md
# select_my_action

Action-selection block of the sensor-node routing core. On `start` it compares the learned next hop against the learned next sink and classifies the node's forwarding role: best hop, next sink, or self/cluster-head. It drives the chosen node ID on `action` and writes the decision into the node flag region of the shared 16-bit data memory (`mem`) through a write-only port.

## Interface
Parameters:
- WORD_WIDTH, 16, data/ID width.
- ADDR_WIDTH, 11, memory byte-address width.
- SINK_ID_BASE, 64, node IDs ≥ this value are sinks.
- FLAG_BASE, 11'h000, base of the flag region; 2 bytes per word.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- en  in  1  re-arm: clears `done` and returns to IDLE; has priority over `start`.
- start  in  1  level request; sampled only in IDLE.
- address  out  11  memory byte address, registered.
- wr_en  out  1  memory write strobe; the memory writes on the rising edge where it is high.
- nexthop  in  16  best next-hop node ID.
- nextsinks  in  16  best next-sink node ID.
- action  out  16  chosen node ID, registered.
- data_out  out  16  memory write data, registered.
- forAggregation  out  1  high in the self/cluster-head role.
- done  out  1  high from completion until `en` or reset.

## Operation
- Classification, evaluated in DECIDE, first match wins:
  - nexthop == nextsinks: self. action=nexthop, code=2, forAggregation=1.
  - nexthop ≥ SINK_ID_BASE: next sink. action=nextsinks, code=1, forAggregation=0.
  - Otherwise: best hop. action=nexthop, code=0, forAggregation=0.
- Code 3 (explore) is reserved and never produced.
- Comparisons are unsigned, full 16 bits.
- Memory write-back, one word per cycle, always in this order:
  - FLAG_BASE+2: {15'b0, forAggregation}
  - FLAG_BASE+4: {14'b0, code}
  - FLAG_BASE+6: action
- FSM states: IDLE, DECIDE, WR_AGG, WR_CODE, WR_HOP, DONE.
- Transitions:
  - IDLE: start=1 and en=0 → DECIDE.
  - DECIDE → WR_AGG → WR_CODE → WR_HOP → DONE, one cycle each.
  - DONE: hold until en=1 → IDLE.
  - en=1 in any state → IDLE. This aborts any remaining writes and forces wr_en low next cycle.
- nexthop and nextsinks are sampled in DECIDE only. Later input changes do not alter the results of the current run.
- `start` held high while in DONE does not retrigger a run. A new run requires an en pulse; if start is still high when IDLE is reached, the next run begins.

## Timing
- Reset (async, nrst=0): state=IDLE. action, data_out, address, wr_en, forAggregation and done are all 0.
- Reset mid-operation: immediate abort; any write in flight is dropped.
- Latency: start sampled at edge 0 → state DECIDE.
  - Edge 1: action and forAggregation valid; WR_AGG entered; wr_en=1.
  - Edges 2 and 3: WR_CODE, then WR_HOP.
  - Edge 4: done=1, wr_en=0.
- wr_en is high for exactly 3 consecutive cycles per run, with address and data_out stable each cycle.
- action and forAggregation hold their values until the next DECIDE or reset. en does not clear them.
- done clears on the edge after en is sampled high.

## Configuration
- Macro SMA_MEM_WRITEBACK_EN.
- Defined: full write-back sequence as above.
- Undefined:
  - WR_* states are omitted; DECIDE → DONE (done at edge 2).
  - wr_en, address and data_out are tied to 0.
  - Classification and action are unchanged.

## Test plan
- Reset: drive nrst low mid-run → all outputs 0 immediately; wr_en stays 0 after release until the next start.
- Best hop: nexthop=51, nextsinks=65, start=1 → action=51, forAggregation=0; writes 0x002=0, 0x004=0, 0x006=51; done 4 cycles after start.
- Next sink: en pulse, then nexthop=65, nextsinks=45 → action=45, forAggregation=0; writes 0x002=0, 0x004=1, 0x006=45.
- Self: en pulse, then nexthop=65, nextsinks=65 → action=65, forAggregation=1; writes 0x002=1, 0x004=2, 0x006=65.
- Hold start high for 200 ns after done → exactly 3 writes total and done stays high. Then en=1 for one cycle → done=0 and a new run starts.
- en asserted during WR_CODE → the 0x006 write never occurs; FSM is in IDLE the next cycle.
